// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared seven-segment encodings: segment bit positions, glyph
//               table, receiver FSM states and anode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } seg_state_e;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high gfedcba pattern for each hex nibble.
    function automatic logic [6:0] glyph_of(input logic [3:0] val);
        logic [6:0] g;
        case (val)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    function automatic logic anode_onehot_low(input logic [3:0] an);
        logic [3:0] act;
        act = ~an;
        return (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] anode_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_glyph_dec.sv
// ============================================================================
// Module      : seven_seg_glyph_dec
// Description : Combinational active-high segment pattern to hex nibble decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_glyph_dec
    import seven_seg_pkg::*;
(
    input  logic [6:0] segs,
    output logic [3:0] value,
    output logic       legal
);

    always_comb begin
        value = 4'd0;
        legal = 1'b0;
        for (int v = 0; v < 16; v++) begin
            if (glyph_of(4'(v)) == segs) begin
                value = 4'(v);
                legal = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seven_seg_rx.sv
// ============================================================================
// Module      : seven_seg_rx
// Description : Samples a multiplexed seven-segment display bus and recovers
//               the per-digit hex values, decimal points and validity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_rx
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  seven_seg,
    input  logic [3:0]  anode,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  dp,
    output logic        update,
    output logic        glyph_err
);

    localparam logic [7:0]  STABLE_C   = 8'(STABLE_CYCLES);
    localparam logic [15:0] TMO_MAX_C  = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] TMO_LAST_C = 16'(TIMEOUT_CYCLES - 1);

    // Sample layout: {anode[3:0], seven_seg[7:0]}
    logic [11:0]       sync1_q, sync2_q, prev_q;
    seg_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0][15:0]  tmo_q, tmo_d;
    logic [15:0]       digits_q, digits_d;
    logic [3:0]        valid_q, valid_d;
    logic [3:0]        dp_q, dp_d;
    logic              update_q, update_d;
    logic              glyph_err_q, glyph_err_d;

    logic              changed, onehot, accept, legal;
    logic [3:0]        value;
    logic [1:0]        idx;

    assign changed = (sync2_q != prev_q);
    assign onehot  = anode_onehot_low(sync2_q[11:8]);
    assign idx     = anode_index(prev_q[11:8]);

    seven_seg_glyph_dec u_dec (
        .segs  (~prev_q[SEG_G:SEG_A]),
        .value (value),
        .legal (legal)
    );

    // The counter tracks how many times prev_q has been seen in a row, so
    // the accepted pattern is prev_q, not the current sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (onehot) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            ST_SETTLE, ST_HELD: begin
                if (state_q == ST_SETTLE) begin
                    if (cnt_q == STABLE_C) begin
                        accept  = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                if (changed) begin
                    if (onehot) begin
                        state_d = ST_SETTLE;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = ST_BLANK;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Timeouts are applied first so that an accept on the same digit wins.
    always_comb begin
        digits_d    = digits_q;
        valid_d     = valid_q;
        dp_d        = dp_q;
        tmo_d       = tmo_q;
        glyph_err_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (tmo_q[i] != TMO_MAX_C) tmo_d[i] = tmo_q[i] + 16'd1;
            if (tmo_q[i] == TMO_LAST_C) valid_d[i] = 1'b0;
        end
        if (accept) begin
            if (legal) begin
                digits_d[{idx, 2'b00} +: 4] = value;
                dp_d[idx]                   = ~prev_q[SEG_DP];
                valid_d[idx]                = 1'b1;
                tmo_d[idx]                  = 16'd0;
            end else begin
                glyph_err_d  = 1'b1;
                valid_d[idx] = 1'b0;
            end
        end
        update_d = (digits_d != digits_q) || (dp_d != dp_q) || (valid_d != valid_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            prev_q      <= '1;
            state_q     <= ST_BLANK;
            cnt_q       <= 8'd0;
            tmo_q       <= '0;
            digits_q    <= 16'd0;
            valid_q     <= 4'd0;
            dp_q        <= 4'd0;
            update_q    <= 1'b0;
            glyph_err_q <= 1'b0;
        end else begin
            sync1_q     <= {anode, seven_seg};
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            dp_q        <= dp_d;
            update_q    <= update_d;
            glyph_err_q <= glyph_err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign dp          = dp_q;
    assign update      = update_q;
    assign glyph_err   = glyph_err_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_rx.sv
// ============================================================================
// Module      : tb_seven_seg_rx
// Description : Directed self-checking bench for seven_seg_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_rx;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  seven_seg;
    logic [3:0]  anode;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  dp;
    logic        update;
    logic        glyph_err;

    int total = 0;
    int bad   = 0;
    int cyc;
    int upd_cnt;
    int err_cnt;

    always #5 clk = ~clk;

    seven_seg_rx #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .seven_seg   (seven_seg),
        .anode       (anode),
        .digits      (digits),
        .digit_valid (digit_valid),
        .dp          (dp),
        .update      (update),
        .glyph_err   (glyph_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (update)    upd_cnt++;
        if (glyph_err) err_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        anode     = 4'hF;
        seven_seg = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rstn    = 1'b1;
        cyc     = 0;
        upd_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (digits !== 16'h0) begin bad++; $display("FAIL reset_digits got=%h exp=%h", digits, 16'h0); end
        total++; if (digit_valid !== 4'h0) begin bad++; $display("FAIL reset_valid got=%b exp=%b", digit_valid, 4'h0); end
        total++; if (dp !== 4'h0) begin bad++; $display("FAIL reset_dp got=%b exp=%b", dp, 4'h0); end
        total++; if ({update, glyph_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {update, glyph_err}); end
    endtask

    task automatic test_single();
        do_reset();
        anode = 4'b1110; seven_seg = 8'hC0;
        run(6);
        total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL single_early got=%b exp=0000", digit_valid); end
        step();
        total++; if (update !== 1'b1) begin bad++; $display("FAIL single_update_at7 got=%b exp=1", update); end
        total++; if (digit_valid !== 4'b0001) begin bad++; $display("FAIL single_valid got=%b exp=0001", digit_valid); end
        total++; if (digits[3:0] !== 4'h0) begin bad++; $display("FAIL single_digit got=%h exp=0", digits[3:0]); end
        run(3);
        total++; if (upd_cnt !== 1) begin bad++; $display("FAIL single_upd_count got=%0d exp=1", upd_cnt); end
    endtask

    task automatic test_scan();
        logic [7:0] pats [4];
        pats = '{8'hF9, 8'h88, 8'h78, 8'h8E};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            anode     = ~(4'b0001 << i);
            seven_seg = pats[i];
            run(8);
        end
        anode = 4'hF; seven_seg = 8'hFF;
        run(10);
        total++; if (digits !== 16'hF7A1) begin bad++; $display("FAIL scan_digits got=%h exp=F7A1", digits); end
        total++; if (dp !== 4'b0100) begin bad++; $display("FAIL scan_dp got=%b exp=0100", dp); end
        total++; if (digit_valid !== 4'b1111) begin bad++; $display("FAIL scan_valid got=%b exp=1111", digit_valid); end
        total++; if (upd_cnt !== 4) begin bad++; $display("FAIL scan_upd_count got=%0d exp=4", upd_cnt); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL scan_err_count got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_toggle();
        do_reset();
        anode = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            seven_seg = (k % 2 == 1) ? 8'h88 : 8'hF9;
            run(2);
        end
        anode = 4'hF; seven_seg = 8'hFF;
        run(10);
        total++; if (upd_cnt !== 0) begin bad++; $display("FAIL toggle_upd_count got=%0d exp=0", upd_cnt); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL toggle_err_count got=%0d exp=0", err_cnt); end
        total++; if ({digits, digit_valid} !== 20'h0) begin bad++; $display("FAIL toggle_outputs got=%h exp=00000", {digits, digit_valid}); end
    endtask

    task automatic test_illegal();
        do_reset();
        anode = 4'b1110; seven_seg = 8'hF9;
        run(10);
        anode = 4'b1100;
        run(10);
        total++; if (upd_cnt !== 1) begin bad++; $display("FAIL twolow_upd_count got=%0d exp=1", upd_cnt); end
        total++; if (digit_valid !== 4'b0001) begin bad++; $display("FAIL twolow_valid got=%b exp=0001", digit_valid); end
        anode = 4'b1110; seven_seg = 8'hFF;
        run(10);
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL blank_err_count got=%0d exp=1", err_cnt); end
        total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL blank_valid got=%b exp=0000", digit_valid); end
        total++; if (digits[3:0] !== 4'h1) begin bad++; $display("FAIL blank_retain got=%h exp=1", digits[3:0]); end
        total++; if (upd_cnt !== 2) begin bad++; $display("FAIL blank_upd_count got=%0d exp=2", upd_cnt); end
        seven_seg = 8'h81;
        run(10);
        total++; if (err_cnt !== 2) begin bad++; $display("FAIL badglyph_err_count got=%0d exp=2", err_cnt); end
        total++; if (upd_cnt !== 2) begin bad++; $display("FAIL badglyph_upd_count got=%0d exp=2", upd_cnt); end
    endtask

    task automatic test_no_change();
        do_reset();
        anode = 4'b1110; seven_seg = 8'hF9;
        run(10);
        anode = 4'hF; seven_seg = 8'hFF;
        run(5);
        anode = 4'b1110; seven_seg = 8'hF9;
        run(10);
        total++; if (upd_cnt !== 1) begin bad++; $display("FAIL reaccept_upd_count got=%0d exp=1", upd_cnt); end
        total++; if (digit_valid !== 4'b0001) begin bad++; $display("FAIL reaccept_valid got=%b exp=0001", digit_valid); end
    endtask

    task automatic test_timeout();
        int w;
        do_reset();
        anode = 4'b0111; seven_seg = 8'h86;
        run(7);
        total++; if (update !== 1'b1) begin bad++; $display("FAIL tmo_load_update got=%b exp=1", update); end
        w = cyc;
        anode = 4'hF; seven_seg = 8'hFF;
        while (cyc < w + 1023) step();
        total++; if (digit_valid[3] !== 1'b1) begin bad++; $display("FAIL tmo_before got=%b exp=1", digit_valid[3]); end
        step();
        total++; if (digit_valid[3] !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", digit_valid[3]); end
        total++; if (update !== 1'b1) begin bad++; $display("FAIL tmo_update got=%b exp=1", update); end
        total++; if (digits[15:12] !== 4'hE) begin bad++; $display("FAIL tmo_retain got=%h exp=E", digits[15:12]); end
        run(5);
        total++; if (upd_cnt !== 2) begin bad++; $display("FAIL tmo_upd_count got=%0d exp=2", upd_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        anode = 4'b1110; seven_seg = 8'hF9;
        run(10);
        anode = 4'b1101; seven_seg = 8'h92;
        run(4);
        rstn = 1'b0;
        #2;
        total++; if ({digits, digit_valid, dp} !== 24'h0) begin bad++; $display("FAIL midrst_async got=%h exp=000000", {digits, digit_valid, dp}); end
        repeat (2) @(posedge clk);
        #1;
        rstn    = 1'b1;
        cyc     = 0;
        upd_cnt = 0;
        run(6);
        total++; if (upd_cnt !== 0 || digit_valid !== 4'b0000) begin bad++; $display("FAIL midrst_early upd=%0d valid=%b exp 0/0000", upd_cnt, digit_valid); end
        step();
        total++; if (update !== 1'b1) begin bad++; $display("FAIL midrst_update got=%b exp=1", update); end
        total++; if (digits !== 16'h0050) begin bad++; $display("FAIL midrst_digits got=%h exp=0050", digits); end
        total++; if (digit_valid !== 4'b0010) begin bad++; $display("FAIL midrst_valid got=%b exp=0010", digit_valid); end
    endtask

    initial begin
        rstn      = 1'b0;
        anode     = 4'hF;
        seven_seg = 8'hFF;
        cyc       = 0;
        upd_cnt   = 0;
        err_cnt   = 0;
        test_reset();
        test_single();
        test_scan();
        test_toggle();
        test_illegal();
        test_no_change();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

`default_nettype wire
